// File: rtl/calculadora_rpn_pilha_pkg.sv
// Shared definitions for the stack-based RPN calculator:
// command codes, ALU op codes, FSM states and op arity.
package calculadora_rpn_pilha_pkg;

    typedef enum logic [1:0] {
        CMD_PUSH  = 2'b00,
        CMD_OP    = 2'b01,
        CMD_POP   = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

    // Bit n set means sel_op==n consumes only the top entry (NOT, SHL, SHR).
    localparam logic [7:0] OP_UNARY_MASK = 8'b1110_0000;

    function automatic logic op_is_unary(input logic [2:0] sel);
        return OP_UNARY_MASK[sel];
    endfunction

endpackage

// File: rtl/calculadora_rpn_pilha_ula.sv
// Combinational WIDTH-bit ALU: a is next-on-stack, b is top.
// carry_valid marks the ops that update the carry flag.
module ula_nbits
    import calculadora_rpn_pilha_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel_op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             carry_valid
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result      = '0;
        carry_out   = 1'b0;
        carry_valid = 1'b0;
        case (sel_op)
            OP_ADD: begin
                {carry_out, result} = sum;
                carry_valid         = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (a < b).
                {carry_out, result} = diff;
                carry_valid         = 1'b1;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~b;
            OP_SHL: begin
                result      = {b[WIDTH-2:0], 1'b0};
                carry_out   = b[WIDTH-1];
                carry_valid = 1'b1;
            end
            OP_SHR: begin
                result      = {1'b0, b[WIDTH-1:1]};
                carry_out   = b[0];
                carry_valid = 1'b1;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/calculadora_rpn_pilha.sv
// RPN calculator with a DEPTH-entry operand stack and a valid/ready command port.
// PUSH/POP/CLEAR finish in IDLE; OP runs IDLE -> EXEC -> WB -> IDLE.
module calculadora_rpn_pilha
    import calculadora_rpn_pilha_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd,
    input  logic [WIDTH-1:0]           operand,
    input  logic [2:0]                 sel_op,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       carry,
    output logic                       zero,
    output logic                       err_overflow,
    output logic                       err_underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_TWO  = DW'(2);
    localparam logic [DW-1:0] D_FULL = DW'(DEPTH);

    state_e            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              carry_q, carry_d;
    logic              err_ov_q, err_ov_d;
    logic              err_uf_q, err_uf_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              res_carry_q, res_carry_d;
    logic              res_cv_q, res_cv_d;

    logic [WIDTH-1:0]  stack_q [DEPTH];
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [WIDTH-1:0]  wr_data;

    logic [IW-1:0]     top_idx, nos_idx;
    logic [WIDTH-1:0]  top_val, nos_val;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry, alu_cv;

    assign top_idx = IW'(depth_q - D_ONE);
    assign nos_idx = IW'(depth_q - D_TWO);
    assign top_val = (depth_q != '0)    ? stack_q[top_idx] : '0;
    assign nos_val = (depth_q >= D_TWO) ? stack_q[nos_idx] : '0;

    ula_nbits #(.WIDTH(WIDTH)) u_ula (
        .a           (nos_val),
        .b           (top_val),
        .sel_op      (op_q),
        .result      (alu_result),
        .carry_out   (alu_carry),
        .carry_valid (alu_cv)
    );

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        carry_d     = carry_q;
        err_ov_d    = err_ov_q;
        err_uf_d    = err_uf_q;
        op_d        = op_q;
        res_d       = res_q;
        res_carry_d = res_carry_q;
        res_cv_d    = res_cv_q;
        wr_en       = 1'b0;
        wr_idx      = top_idx;
        wr_data     = res_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_PUSH: begin
                            if (depth_q < D_FULL) begin
                                wr_en   = 1'b1;
                                wr_idx  = IW'(depth_q);
                                wr_data = operand;
                                depth_d = depth_q + D_ONE;
                            end else begin
                                err_ov_d = 1'b1;
                            end
                        end
                        CMD_POP: begin
                            if (depth_q != '0) depth_d  = depth_q - D_ONE;
                            else               err_uf_d = 1'b1;
                        end
                        CMD_CLEAR: begin
                            depth_d  = '0;
                            carry_d  = 1'b0;
                            err_ov_d = 1'b0;
                            err_uf_d = 1'b0;
                        end
                        default: begin // CMD_OP
                            if (op_is_unary(sel_op) ? (depth_q >= D_ONE) : (depth_q >= D_TWO)) begin
                                op_d    = sel_op;
                                state_d = EXEC;
                            end else begin
                                err_uf_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            EXEC: begin
                res_d       = alu_result;
                res_carry_d = alu_carry;
                res_cv_d    = alu_cv;
                state_d     = WB;
            end
            WB: begin
                // Binary ops land in the NOS slot and drop the old top.
                wr_en = 1'b1;
                if (!op_is_unary(op_q)) begin
                    wr_idx  = nos_idx;
                    depth_d = depth_q - D_ONE;
                end
                if (res_cv_q) carry_d = res_carry_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            depth_q     <= '0;
            carry_q     <= 1'b0;
            err_ov_q    <= 1'b0;
            err_uf_q    <= 1'b0;
            op_q        <= '0;
            res_q       <= '0;
            res_carry_q <= 1'b0;
            res_cv_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            carry_q     <= carry_d;
            err_ov_q    <= err_ov_d;
            err_uf_q    <= err_uf_d;
            op_q        <= op_d;
            res_q       <= res_d;
            res_carry_q <= res_carry_d;
            res_cv_q    <= res_cv_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset)                               stack_q[gi] <= '0;
                else if (wr_en && (wr_idx == IW'(gi)))   stack_q[gi] <= wr_data;
            end
        end
    endgenerate

    assign cmd_ready     = (state_q == IDLE);
    assign top           = top_val;
    assign depth         = depth_q;
    assign carry         = carry_q;
    assign zero          = (depth_q != '0) && (top_val == '0);
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_uf_q;

endmodule

// File: tb/tb_calculadora_rpn_pilha.sv
// Directed bench for calculadora_rpn_pilha (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_calculadora_rpn_pilha;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd = 2'b00;
    logic [WIDTH-1:0] operand = '0;
    logic [2:0]       sel_op = 3'b000;
    logic [WIDTH-1:0] top;
    logic [2:0]       depth;
    logic             carry, zero, err_overflow, err_underflow;

    int checks = 0;
    int errors = 0;
    int n;

    calculadora_rpn_pilha #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .operand       (operand),
        .sel_op        (sel_op),
        .top           (top),
        .depth         (depth),
        .carry         (carry),
        .zero          (zero),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One accepted command; returns 1 ns after the accepting edge.
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic [2:0] s);
        cmd       = c;
        operand   = d;
        sel_op    = s;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        do_cmd(2'b00, d, 3'b000);
    endtask

    // Issue OP and count the cycles cmd_ready stays low (bounded).
    task automatic do_op(input logic [2:0] s, output int busy);
        do_cmd(2'b01, 8'h00, s);
        busy = 0;
        while (!cmd_ready && busy < 10) begin
            busy++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_depth", 32'(depth), 0);
        check("rst_top", 32'(top), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_ovf", 32'(err_overflow), 0);
        check("rst_udf", 32'(err_underflow), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        reset = 1'b0;

        // Basic ADD
        push(8'd5); push(8'd3);
        do_op(3'b000, n);
        check("add_busy", 32'(n), 2);
        check("add_top", 32'(top), 8);
        check("add_depth", 32'(depth), 1);
        check("add_carry", 32'(carry), 0);
        check("add_zero", 32'(zero), 0);
        do_cmd(2'b11, 8'h00, 3'b000);

        // ADD with carry, then SHL
        push(8'd200); push(8'd100);
        do_op(3'b000, n);
        check("addc_top", 32'(top), 44);
        check("addc_carry", 32'(carry), 1);
        do_op(3'b110, n);
        check("shl_top", 32'(top), 88);
        check("shl_carry", 32'(carry), 0);
        check("shl_depth", 32'(depth), 1);
        do_cmd(2'b11, 8'h00, 3'b000);

        // SUB with borrow, then XOR to zero
        push(8'd3); push(8'd5);
        do_op(3'b001, n);
        check("sub_top", 32'(top), 32'hFE);
        check("sub_carry", 32'(carry), 1);
        push(8'hFE);
        do_op(3'b100, n);
        check("xor_top", 32'(top), 0);
        check("xor_zero", 32'(zero), 1);
        check("xor_depth", 32'(depth), 1);
        check("xor_carry_kept", 32'(carry), 1);
        do_cmd(2'b11, 8'h00, 3'b000);
        check("clr_carry", 32'(carry), 0);

        // Overflow then CLEAR
        push(8'd1); push(8'd2); push(8'd3); push(8'd4); push(8'd9);
        check("ovf_depth", 32'(depth), 4);
        check("ovf_top", 32'(top), 4);
        check("ovf_flag", 32'(err_overflow), 1);
        do_cmd(2'b11, 8'h00, 3'b000);
        check("clr_depth", 32'(depth), 0);
        check("clr_top", 32'(top), 0);
        check("clr_ovf", 32'(err_overflow), 0);

        // Underflow, illegal OP, unary ops, POP
        do_cmd(2'b10, 8'h00, 3'b000);
        check("udf_flag", 32'(err_underflow), 1);
        check("udf_depth", 32'(depth), 0);
        push(8'h0F);
        do_cmd(2'b01, 8'h00, 3'b000);
        check("ill_ready", 32'(cmd_ready), 1);
        check("ill_udf", 32'(err_underflow), 1);
        check("ill_top", 32'(top), 32'h0F);
        check("ill_depth", 32'(depth), 1);
        do_op(3'b101, n);
        check("not_busy", 32'(n), 2);
        check("not_top", 32'(top), 32'hF0);
        push(8'h03);
        do_op(3'b111, n);
        check("shr_top", 32'(top), 1);
        check("shr_carry", 32'(carry), 1);
        check("shr_depth", 32'(depth), 2);
        do_cmd(2'b10, 8'h00, 3'b000);
        check("pop_top", 32'(top), 32'hF0);
        check("pop_depth", 32'(depth), 1);
        push(8'h0F);
        do_op(3'b011, n);
        check("or_top", 32'(top), 32'hFF);
        check("or_depth", 32'(depth), 1);
        check("udf_sticky", 32'(err_underflow), 1);
        do_cmd(2'b11, 8'h00, 3'b000);
        check("clr_udf", 32'(err_underflow), 0);

        // Reset during EXEC discards the op
        push(8'd1); push(8'd2);
        do_cmd(2'b01, 8'h00, 3'b000);
        check("mid_ready_exec", 32'(cmd_ready), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_depth", 32'(depth), 0);
        check("mid_top", 32'(top), 0);
        check("mid_carry", 32'(carry), 0);
        check("mid_ready", 32'(cmd_ready), 1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_depth", 32'(depth), 0);
        check("post_top", 32'(top), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
